control_sequencer: RTL

//  Hardwired Moore control unit driving the phase-1 datapath strobes (PCout, MARin, IncPC, Read, MDRin, IRin, Yin, Z, LO/HI, ...).

---
 rtl/control_sequencer_pkg.sv | 52 +++++
 rtl/control_sequencer_if.sv | 51 +++++
 rtl/control_sequencer_cu_decode.sv | 24 ++
 rtl/control_sequencer.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/control_sequencer_pkg.sv
// Shared definitions for the hardwired control sequencer:
// opcodes, IR field positions, state encoding and decode classes.
package control_sequencer_pkg;

    localparam int IR_OP_MSB = 31;
    localparam int IR_OP_LSB = 27;
    localparam int IR_RA_LSB = 23;
    localparam int IR_RB_LSB = 19;
    localparam int IR_RC_LSB = 15;

    localparam logic [4:0] OP_ADD  = 5'd3;
    localparam logic [4:0] OP_SUB  = 5'd4;
    localparam logic [4:0] OP_AND  = 5'd5;
    localparam logic [4:0] OP_OR   = 5'd6;
    localparam logic [4:0] OP_SHR  = 5'd7;
    localparam logic [4:0] OP_SHRA = 5'd8;
    localparam logic [4:0] OP_SHL  = 5'd9;
    localparam logic [4:0] OP_ROR  = 5'd10;
    localparam logic [4:0] OP_ROL  = 5'd11;
    localparam logic [4:0] OP_MUL  = 5'd15;
    localparam logic [4:0] OP_DIV  = 5'd16;
    localparam logic [4:0] OP_NEG  = 5'd17;
    localparam logic [4:0] OP_NOT  = 5'd18;
    localparam logic [4:0] OP_NOP  = 5'd25;
    localparam logic [4:0] OP_HALT = 5'd26;

    typedef enum logic [3:0] {
        S_IDLE,
        S_T0,
        S_T1,
        S_T2,
        S_T3,
        S_T4,
        S_T5,
        S_T6,
        S_HALT
    } state_t;

    typedef struct packed {
        logic is_bin;
        logic is_muldiv;
        logic is_unary;
        logic is_nop;
        logic is_halt;
        logic illegal;
    } op_class_t;

    function automatic logic [4:0] ir_op(input logic [31:0] ir);
        return ir[IR_OP_MSB:IR_OP_LSB];
    endfunction

endpackage

// File: rtl/control_sequencer_if.sv
// Control-unit to datapath bundle: sequencer inputs, datapath
// strobes and status. master = sequencer, slave = datapath/bench.
interface control_sequencer_if #(
    parameter int CNT_W = 16
);
    logic             start;
    logic             mem_ready;
    logic [31:0]      ir;
    logic             PCout;
    logic             PCin;
    logic             IncPC;
    logic             MARin;
    logic             Read;
    logic             MDRin;
    logic             MDRout;
    logic             IRin;
    logic             Yin;
    logic             ZLowIn;
    logic             ZHighIn;
    logic             ZLowOut;
    logic             ZHighOut;
    logic             LOin;
    logic             HIin;
    logic             Gra;
    logic             Grb;
    logic             Grc;
    logic             Rin;
    logic             Rout;
    logic [4:0]       alu_op;
    logic             run;
    logic             fault;
    logic [CNT_W-1:0] retired;

    modport master (
        input  start, mem_ready, ir,
        output PCout, PCin, IncPC, MARin, Read, MDRin,
        output MDRout, IRin, Yin, ZLowIn, ZHighIn,
        output ZLowOut, ZHighOut, LOin, HIin,
        output Gra, Grb, Grc, Rin, Rout,
        output alu_op, run, fault, retired
    );

    modport slave (
        output start, mem_ready, ir,
        input  PCout, PCin, IncPC, MARin, Read, MDRin,
        input  MDRout, IRin, Yin, ZLowIn, ZHighIn,
        input  ZLowOut, ZHighOut, LOin, HIin,
        input  Gra, Grb, Grc, Rin, Rout,
        input  alu_op, run, fault, retired
    );
endinterface

// File: rtl/control_sequencer_cu_decode.sv
// Opcode classifier: maps the 5-bit opcode to the execution
// class that steers T3..T6 of the sequencer.
module cu_decode
    import control_sequencer_pkg::*;
(
    input  logic [4:0] op,
    output op_class_t  cls
);

    // Exactly one class bit is set for any opcode.
    always_comb begin
        cls = '0;
        unique case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR,
            OP_SHRA, OP_SHL, OP_ROR, OP_ROL: cls.is_bin = 1'b1;
            OP_MUL, OP_DIV:                  cls.is_muldiv = 1'b1;
            OP_NEG, OP_NOT:                  cls.is_unary = 1'b1;
            OP_NOP:                          cls.is_nop = 1'b1;
            OP_HALT:                         cls.is_halt = 1'b1;
            default:                         cls.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired Moore control unit for the phase-1 datapath: fetch,
// then execute ALU, mul/div, neg/not, nop and halt instructions.
module control_sequencer
    import control_sequencer_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 16
) (
    input logic          clock,
    input logic          clear,
    control_sequencer_if.master bus
);

    localparam int WW = $clog2(MEM_TIMEOUT + 1);

    state_t           state_q, state_d;
    logic [WW-1:0]    wait_q, wait_d;
    logic             fault_q, fault_d;
    logic             retire;
    logic [CNT_W-1:0] retired_q;
    logic [4:0]       op;
    op_class_t        cls;

    assign op = ir_op(bus.ir);

    cu_decode u_decode (
        .op  (op),
        .cls (cls)
    );

    // State, memory-wait counter, sticky fault and retire count.
    always_ff @(posedge clock) begin
        if (clear) begin
            state_q   <= S_IDLE;
            wait_q    <= '0;
            fault_q   <= 1'b0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            fault_q   <= fault_d;
            retired_q <= retired_q + CNT_W'(retire);
        end
    end

    // Next-state sequencing; T3 branches on the opcode class.
    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        fault_d = fault_q;
        retire  = 1'b0;
        unique case (state_q)
            S_IDLE: if (bus.start) state_d = S_T0;
            S_T0: begin
                state_d = S_T1;
                wait_d  = '0;
            end
            S_T1: begin
                if (bus.mem_ready) begin
                    state_d = S_T2;
                    wait_d  = '0;
                end else if (wait_q == WW'(MEM_TIMEOUT - 1)) begin
                    state_d = S_HALT;
                    fault_d = 1'b1;
                end else begin
                    wait_d = wait_q + WW'(1);
                end
            end
            S_T2: state_d = S_T3;
            S_T3: begin
                if (cls.is_nop) begin
                    state_d = S_T0;
                    retire  = 1'b1;
                end else if (cls.is_halt) begin
                    state_d = S_HALT;
                    retire  = 1'b1;
                end else if (cls.illegal) begin
                    state_d = S_HALT;
                    fault_d = 1'b1;
                end else begin
                    state_d = S_T4;
                end
            end
            S_T4: state_d = S_T5;
            S_T5: begin
                if (cls.is_muldiv) begin
                    state_d = S_T6;
                end else begin
                    state_d = S_T0;
                    retire  = 1'b1;
                end
            end
            S_T6: begin
                state_d = S_T0;
                retire  = 1'b1;
            end
            S_HALT: state_d = S_HALT;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath strobes decoded from state and IR; only one bus driver per state.
    always_comb begin
        bus.PCout    = 1'b0;
        bus.PCin     = 1'b0;
        bus.IncPC    = 1'b0;
        bus.MARin    = 1'b0;
        bus.Read     = 1'b0;
        bus.MDRin    = 1'b0;
        bus.MDRout   = 1'b0;
        bus.IRin     = 1'b0;
        bus.Yin      = 1'b0;
        bus.ZLowIn   = 1'b0;
        bus.ZHighIn  = 1'b0;
        bus.ZLowOut  = 1'b0;
        bus.ZHighOut = 1'b0;
        bus.LOin     = 1'b0;
        bus.HIin     = 1'b0;
        bus.Gra      = 1'b0;
        bus.Grb      = 1'b0;
        bus.Grc      = 1'b0;
        bus.Rin      = 1'b0;
        bus.Rout     = 1'b0;
        bus.alu_op   = '0;
        unique case (state_q)
            S_T0: begin
                bus.PCout  = 1'b1;
                bus.MARin  = 1'b1;
                bus.IncPC  = 1'b1;
                bus.ZLowIn = 1'b1;
            end
            S_T1: begin
                bus.ZLowOut = 1'b1;
                bus.PCin    = 1'b1;
                bus.Read    = 1'b1;
                bus.MDRin   = 1'b1;
            end
            S_T2: begin
                bus.MDRout = 1'b1;
                bus.IRin   = 1'b1;
            end
            S_T3: begin
                if (cls.is_bin || cls.is_muldiv) begin
                    bus.Gra  = cls.is_muldiv;
                    bus.Grb  = cls.is_bin;
                    bus.Rout = 1'b1;
                    bus.Yin  = 1'b1;
                end
            end
            S_T4: begin
                bus.alu_op  = op;
                bus.ZLowIn  = 1'b1;
                bus.ZHighIn = cls.is_muldiv;
                bus.Grc     = cls.is_bin;
                bus.Grb     = !cls.is_bin;
                bus.Rout    = 1'b1;
            end
            S_T5: begin
                bus.ZLowOut = 1'b1;
                bus.LOin    = cls.is_muldiv;
                bus.Gra     = !cls.is_muldiv;
                bus.Rin     = !cls.is_muldiv;
            end
            S_T6: begin
                bus.ZHighOut = 1'b1;
                bus.HIin     = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.run     = (state_q != S_IDLE) && (state_q != S_HALT);
    assign bus.fault   = fault_q;
    assign bus.retired = retired_q;

endmodule
